// File: rtl/animate_sprite.sv
// Sprite mover: erases the sprite, steps its origin by one clamped move, then redraws it.
// Define SPRITE_ERASE_EN to include the background erase pass before the move.
module animate_sprite #(
  parameter int         X_W   = 8,
  parameter int         Y_W   = 7,
  parameter int         SPR_W = 20,
  parameter int         SPR_H = 20,
  parameter int         STEP  = 3,
  parameter int         SCR_W = 160,
  parameter int         SCR_H = 120,
  parameter logic [2:0] FG    = 3'b110,
  parameter logic [2:0] BG    = 3'b000
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           go,
  input  logic           up,
  input  logic           down,
  input  logic           left,
  input  logic           right,
  input  logic [X_W-1:0] in_x,
  input  logic [Y_W-1:0] in_y,
  output logic [X_W-1:0] out_x,
  output logic [Y_W-1:0] out_y,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     colour,
  output logic           plot,
  output logic           done,
  output logic           blocked
);

  localparam int CX_W = $clog2(SPR_W + 1);
  localparam int CY_W = $clog2(SPR_H + 1);
  localparam logic [CX_W-1:0] CX_LAST = CX_W'(SPR_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(SPR_H - 1);
  localparam logic [X_W:0]    X_STEP  = (X_W + 1)'(STEP);
  localparam logic [Y_W:0]    Y_STEP  = (Y_W + 1)'(STEP);
  localparam logic [X_W:0]    X_LIM   = (X_W + 1)'(SCR_W - SPR_W);
  localparam logic [Y_W:0]    Y_LIM   = (Y_W + 1)'(SCR_H - SPR_H);

  typedef enum logic [1:0] {IDLE, ERASE, SHIFT, DRAW} state_t;

  state_t          state_q, state_d;
  logic [X_W-1:0]  pos_x_q, pos_x_d;
  logic [Y_W-1:0]  pos_y_q, pos_y_d;
  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;
  logic            done_q, done_d;
  logic            blocked_q, blocked_d;
  logic            last_px;

  // Saturating moves return {clamped, new_position}; sums use one extra bit.
  function automatic logic [X_W:0] dec_x(input logic [X_W-1:0] p);
    if ({1'b0, p} < X_STEP) return {1'b1, {X_W{1'b0}}};
    return {1'b0, p - X_STEP[X_W-1:0]};
  endfunction

  function automatic logic [X_W:0] inc_x(input logic [X_W-1:0] p);
    logic [X_W:0] s;
    s = {1'b0, p} + X_STEP;
    if (s > X_LIM) return {1'b1, X_LIM[X_W-1:0]};
    return {1'b0, s[X_W-1:0]};
  endfunction

  function automatic logic [Y_W:0] dec_y(input logic [Y_W-1:0] p);
    if ({1'b0, p} < Y_STEP) return {1'b1, {Y_W{1'b0}}};
    return {1'b0, p - Y_STEP[Y_W-1:0]};
  endfunction

  function automatic logic [Y_W:0] inc_y(input logic [Y_W-1:0] p);
    logic [Y_W:0] s;
    s = {1'b0, p} + Y_STEP;
    if (s > Y_LIM) return {1'b1, Y_LIM[Y_W-1:0]};
    return {1'b0, s[Y_W-1:0]};
  endfunction

  assign last_px = (cx_q == CX_LAST) && (cy_q == CY_LAST);

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    cx_d      = '0;
    cy_d      = '0;
    done_d    = 1'b0;
    blocked_d = blocked_q;
    if ((state_q == ERASE || state_q == DRAW) && !last_px) begin
      if (cx_q == CX_LAST) begin
        cy_d = cy_q + CY_W'(1);
      end else begin
        cx_d = cx_q + CX_W'(1);
        cy_d = cy_q;
      end
    end
    case (state_q)
      IDLE: begin
        pos_x_d = in_x;
        pos_y_d = in_y;
        if (go) begin
`ifdef SPRITE_ERASE_EN
          state_d = ERASE;
`else
          state_d = SHIFT;
`endif
        end
      end
      ERASE: if (last_px) state_d = SHIFT;
      SHIFT: begin
        state_d = DRAW;
        if (!up)         {blocked_d, pos_y_d} = dec_y(pos_y_q);
        else if (!down)  {blocked_d, pos_y_d} = inc_y(pos_y_q);
        else if (!left)  {blocked_d, pos_x_d} = dec_x(pos_x_q);
        else if (!right) {blocked_d, pos_x_d} = inc_x(pos_x_q);
        else             blocked_d = 1'b0;
      end
      DRAW: begin
        if (last_px) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      done_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      done_q    <= done_d;
      blocked_q <= blocked_d;
    end
  end

  // Pixel outputs decode straight from the registered state so reset blanks them at once.
  assign plot    = (state_q == ERASE) || (state_q == DRAW);
  assign colour  = (state_q == DRAW) ? FG : BG;
  assign vga_x   = pos_x_q + X_W'(cx_q);
  assign vga_y   = pos_y_q + Y_W'(cy_q);
  assign out_x   = pos_x_q;
  assign out_y   = pos_y_q;
  assign done    = done_q;
  assign blocked = blocked_q;

endmodule

// File: tb/tb_animate_sprite.sv
// Bench for animate_sprite: directed move table, reset/back-to-back sequences, random moves vs a model.
module tb_animate_sprite;

  localparam int X_W = 8, Y_W = 7, SPR_W = 20, SPR_H = 20, STEP = 3;
  localparam int SCR_W = 160, SCR_H = 120, FGI = 6, BGI = 0;
  localparam int N = SPR_W * SPR_H;
`ifdef SPRITE_ERASE_EN
  localparam int NE = N;
`else
  localparam int NE = 0;
`endif
  localparam int LAT = NE + N + 2;

  logic clock = 1'b0, reset = 1'b1, go = 1'b0;
  logic up = 1'b1, down = 1'b1, left = 1'b1, right = 1'b1;
  logic [X_W-1:0] in_x = '0, out_x, vga_x;
  logic [Y_W-1:0] in_y = '0, out_y, vga_y;
  logic [2:0] colour;
  logic plot, done, blocked;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ix; int iy; logic u; logic d; logic l; logic r;
    int ex; int ey; int eb;
  } vec_t;
  vec_t vecs[12];

  animate_sprite dut (
    .clock(clock), .reset(reset), .go(go),
    .up(up), .down(down), .left(left), .right(right),
    .in_x(in_x), .in_y(in_y), .out_x(out_x), .out_y(out_y),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
    .plot(plot), .done(done), .blocked(blocked)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input int ix, input int iy, input logic u, input logic d,
                                input logic l, input logic r,
                                output int ex, output int ey, output int eb);
    ex = ix; ey = iy; eb = 0;
    if (!u) begin
      ey = iy - STEP;
      if (ey < 0) begin ey = 0; eb = 1; end
    end else if (!d) begin
      ey = iy + STEP;
      if (ey > SCR_H - SPR_H) begin ey = SCR_H - SPR_H; eb = 1; end
    end else if (!l) begin
      ex = ix - STEP;
      if (ex < 0) begin ex = 0; eb = 1; end
    end else if (!r) begin
      ex = ix + STEP;
      if (ex > SCR_W - SPR_W) begin ex = SCR_W - SPR_W; eb = 1; end
    end
  endfunction

  task automatic do_move(input string nm, input int ix, input int iy, input logic u,
                         input logic d, input logic l, input logic r,
                         input int ex, input int ey, input int eb);
    int lat, rerr, first, k, ep, ecol, evx, evy;
    bit bad;
    lat = -1; rerr = 0; first = -1;
    @(negedge clock);
    in_x = X_W'(ix); in_y = Y_W'(iy);
    up = u; down = d; left = l; right = r;
    go = 1'b1;
    for (int c = 1; c <= LAT + 10; c++) begin
      @(negedge clock);
      go = 1'b0;
      if (done) begin lat = c; break; end
      evx = 0; evy = 0; ecol = BGI; ep = 0;
      if (c <= NE) begin
        ep = 1; k = c - 1;
        evx = (ix + k % SPR_W) % (1 << X_W);
        evy = (iy + k / SPR_W) % (1 << Y_W);
      end else if (c >= NE + 2 && c <= NE + 1 + N) begin
        ep = 1; ecol = FGI; k = c - NE - 2;
        evx = (ex + k % SPR_W) % (1 << X_W);
        evy = (ey + k / SPR_W) % (1 << Y_W);
      end
      bad = (plot !== ep[0]) || (int'(colour) != ecol);
      if (ep == 1) bad = bad || (int'(vga_x) != evx) || (int'(vga_y) != evy);
      if (c > NE + 1) bad = bad || (int'(out_x) != ex) || (int'(out_y) != ey);
      if (bad) begin
        rerr++;
        if (first < 0) first = c;
      end
    end
    chk({nm, "_latency"}, lat, LAT);
    chk($sformatf("%s_raster_errs(first_cycle=%0d)", nm, first), rerr, 0);
    chk({nm, "_out_x"}, int'(out_x), ex);
    chk({nm, "_out_y"}, int'(out_y), ey);
    chk({nm, "_blocked"}, int'(blocked), eb);
    @(negedge clock);
    chk({nm, "_done_one_cycle"}, int'(done), 0);
    chk({nm, "_idle_plot"}, int'(plot), 0);
    up = 1'b1; down = 1'b1; left = 1'b1; right = 1'b1;
  endtask

  initial begin
    int ex, ey, eb, ndone, last, rx, ry;
    logic [3:0] b;

    vecs[0]  = '{50, 40, 1'b1, 1'b1, 1'b0, 1'b1, 47, 40, 0};
    vecs[1]  = '{1, 10, 1'b1, 1'b1, 1'b0, 1'b1, 0, 10, 1};
    vecs[2]  = '{140, 10, 1'b1, 1'b1, 1'b1, 1'b0, 140, 10, 1};
    vecs[3]  = '{30, 30, 1'b0, 1'b1, 1'b0, 1'b1, 30, 27, 0};
    vecs[4]  = '{30, 30, 1'b1, 1'b1, 1'b1, 1'b1, 30, 30, 0};
    vecs[5]  = '{10, 10, 1'b1, 1'b0, 1'b1, 1'b1, 10, 13, 0};
    vecs[6]  = '{0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 1};
    vecs[7]  = '{3, 5, 1'b1, 1'b1, 1'b0, 1'b1, 0, 5, 0};
    vecs[8]  = '{0, 97, 1'b1, 1'b0, 1'b1, 1'b1, 0, 100, 0};
    vecs[9]  = '{0, 98, 1'b1, 1'b0, 1'b1, 1'b1, 0, 100, 1};
    vecs[10] = '{139, 20, 1'b1, 1'b1, 1'b1, 1'b0, 140, 20, 1};
    vecs[11] = '{137, 20, 1'b1, 1'b0, 1'b0, 1'b0, 137, 23, 0};

    repeat (2) @(negedge clock);
    chk("reset_plot", int'(plot), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_colour", int'(colour), BGI);
    chk("reset_blocked", int'(blocked), 0);
    chk("reset_out_x", int'(out_x), 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      do_move($sformatf("vec%0d", i), vecs[i].ix, vecs[i].iy, vecs[i].u, vecs[i].d,
              vecs[i].l, vecs[i].r, vecs[i].ex, vecs[i].ey, vecs[i].eb);

    // Reset in the middle of the draw pass, after a clamped move set blocked.
    @(negedge clock);
    in_x = 8'd1; in_y = 7'd10; left = 1'b0; go = 1'b1;
    for (int c = 1; c <= NE + 2 + 100; c++) begin
      @(negedge clock);
      go = 1'b0;
    end
    chk("pre_reset_plot", int'(plot), 1);
    chk("pre_reset_blocked", int'(blocked), 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_plot", int'(plot), 0);
    chk("mid_reset_done", int'(done), 0);
    chk("mid_reset_colour", int'(colour), BGI);
    chk("mid_reset_blocked", int'(blocked), 0);
    chk("mid_reset_out_x", int'(out_x), 0);
    @(negedge clock);
    reset = 1'b0; left = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_reset_no_resume", int'(plot), 0);
    do_move("after_reset", 50, 40, 1'b1, 1'b1, 1'b0, 1'b1, 47, 40, 0);

    // go held: three back-to-back runs, origin reloaded in each done cycle.
    @(negedge clock);
    in_x = 8'd50; in_y = 7'd40; left = 1'b0; go = 1'b1;
    ndone = 0; last = 0;
    for (int c = 1; c <= 3 * LAT + 40; c++) begin
      @(negedge clock);
      if (c == 2) in_x = 8'd60;
      if (done) begin
        ndone++;
        if (ndone == 1) chk("b2b_first_done", c, LAT);
        else chk("b2b_gap", c - last, LAT);
        chk("b2b_out_x", int'(out_x), (ndone == 1) ? 47 : 57);
        last = c;
      end else if (ndone >= 2) begin
        go = 1'b0;
      end
    end
    chk("b2b_done_count", ndone, 3);
    go = 1'b0; left = 1'b1;

    for (int i = 0; i < 20; i++) begin
      rx = $urandom_range(0, SCR_W - SPR_W + 4);
      ry = $urandom_range(0, SCR_H - SPR_H + 4);
      b = 4'($urandom_range(0, 15));
      model(rx, ry, b[3], b[2], b[1], b[0], ex, ey, eb);
      do_move($sformatf("rand%0d", i), rx, ry, b[3], b[2], b[1], b[0], ex, ey, eb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/animate_sprite.md
ANIMATE_SPRITE -- requirements
Module: animate_sprite

Interface
REQ-001 The block SHALL have parameter X_W, default 8, meaning x coordinate width.
REQ-002 The block SHALL have parameter Y_W, default 7, meaning y coordinate width.
REQ-003 The block SHALL have parameters SPR_W and SPR_H, default 20 each, meaning sprite width and height in pixels (each >= 1).
REQ-004 The block SHALL have parameter STEP, default 3, meaning pixels moved per SHIFT.
REQ-005 The block SHALL have parameters SCR_W and SCR_H, default 160 and 120, meaning the screen extent.
REQ-006 The block SHALL have parameters FG and BG, default 3'b110 and 3'b000, meaning draw colour and erase colour.
REQ-007 The block SHALL have port clock, input, 1, meaning the single clock; all flops on the rising edge.
REQ-008 The block SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-009 The block SHALL have port go, input, 1, meaning start one move-and-redraw cycle.
REQ-010 The block SHALL have ports up, down, left, right, input, 1 each, meaning active-low direction buttons.
REQ-011 The block SHALL have ports in_x, input, X_W, and in_y, input, Y_W, meaning the current sprite origin.
REQ-012 The block SHALL have ports out_x, output, X_W, and out_y, output, Y_W, meaning the registered sprite origin after the move.
REQ-013 The block SHALL have ports vga_x, output, X_W, and vga_y, output, Y_W, meaning the pixel being plotted.
REQ-014 The block SHALL have ports colour, output, 3, plot, output, 1, and done, output, 1, meaning the pixel colour, the pixel write strobe and the one-cycle completion pulse.
REQ-015 The block SHALL have port blocked, output, 1, meaning the last requested move was clamped at a screen edge.

Function
REQ-016 The FSM SHALL have the states IDLE, ERASE, SHIFT and DRAW, with transitions IDLE->ERASE on go=1, ERASE->SHIFT after the last pixel, SHIFT->DRAW after 1 cycle, and DRAW->IDLE after the last pixel.
REQ-017 In IDLE, the block SHALL load pos_x<=in_x and pos_y<=in_y every cycle; go SHALL be ignored in every other state.
REQ-018 In SHIFT, the block SHALL use direction priority up > down > left > right, and SHALL not move when no button is 0.
REQ-019 Up and left moves SHALL be clamped: if pos<STEP, pos<=0, else pos-STEP.
REQ-020 Down and right moves SHALL be clamped: if pos+STEP > SCR-SPR, pos<=SCR-SPR, else pos+STEP. Sums SHALL be computed at width+1 so that no wrap-around occurs.
REQ-021 The blocked output SHALL be registered in SHIFT: 1 if clamping changed the result (including an origin already at the edge), otherwise 0. It SHALL hold until the next SHIFT.
REQ-022 In ERASE and DRAW, the raster counters cx (0..SPR_W-1, fast) and cy (0..SPR_H-1) SHALL advance one pixel per cycle and reset to 0 on state entry.
REQ-023 In ERASE and DRAW: vga_x=pos_x+cx, vga_y=pos_y+cy, plot=1. plot SHALL be 1 only in ERASE and DRAW.
REQ-024 colour SHALL be BG in ERASE, FG in DRAW, and BG otherwise.
REQ-025 done SHALL be 1 for exactly the one cycle after the final DRAW pixel (state IDLE); out_x and out_y SHALL equal the moved position from SHIFT onward.
REQ-026 Latency from go sampled to done, with the erase pass enabled, SHALL be 2*SPR_W*SPR_H+2 cycles.
REQ-027 With go held at 1, the block SHALL run back-to-back cycles; in_x and in_y SHALL be reloaded in the IDLE cycle where done=1.

Reset
REQ-028 Asserting reset SHALL asynchronously force state IDLE, pos/cx/cy to 0, and plot, done and blocked to 0 and colour to BG, including mid-ERASE or mid-DRAW.
REQ-029 After reset deassertion, the first go SHALL start a full cycle; no partial raster SHALL resume.

Configuration
REQ-030 With SPRITE_ERASE_EN defined, the ERASE state SHALL exist as specified.
REQ-031 Without SPRITE_ERASE_EN, go SHALL take IDLE->SHIFT directly, BG SHALL never be plotted, and latency SHALL be SPR_W*SPR_H+2 cycles.

Verification
REQ-032 Erase enabled, defaults, in=(50,40), left=0, go pulse: 400 BG plots at x 50..69, y 40..59, then 400 FG plots at x 47..66, then done; out=(47,40); blocked=0.
REQ-033 in=(1,10), left=0: out_x=0 and blocked=1; in=(140,10), right=0: out_x=140 and blocked=1.
REQ-034 up=0 and left=0 together with in=(30,30): out=(30,27); no button pressed: out=(30,30) and blocked=0.
REQ-035 Assert reset at DRAW pixel 100: plot=0 and done=0 in the same cycle; the next go produces a full 802-cycle sequence.
REQ-036 Macro undefined, in=(10,10), down=0: no BG plots; 400 FG plots at y 13..32; done at cycle 402.
REQ-037 go held at 1 for three cycles: exactly three done pulses; every pulse is separated by 802 cycles.
